// File: rtl/f_vector_pack_pkg.sv
// Shared types for the F-path collectors: FSM states and element-counter sizing.
package f_vector_pack_pkg;

    typedef enum logic [1:0] {
        FILL,
        FULL,
        DROP
    } state_t;

    function automatic int unsigned j_width(input int unsigned j);
        return $clog2(j) + 1;
    endfunction

endpackage

// File: rtl/f_vector_pack.sv
// Narrow-to-wide collector: packs a framed stream of DW-bit scalars into one J*DW vector.
module f_vector_pack
    import f_vector_pack_pkg::*;
#(
    parameter int unsigned J  = 14,
    parameter int unsigned DW = 64,
    localparam int unsigned J_WIDTH = j_width(J)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DW-1:0]        s_tdata,
    input  logic                 s_tvalid,
    input  logic                 s_tlast,
    output logic                 s_tready,
    output logic [J*DW-1:0]      m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [J_WIDTH-1:0]   m_count,
    output logic                 err_short,
    output logic                 err_long
);

    localparam logic [J_WIDTH-1:0] LAST_IDX = J_WIDTH'(J - 1);
    localparam logic [J_WIDTH-1:0] FULL_CNT = J_WIDTH'(J);

    state_t               state_q, state_d;
    logic [J_WIDTH-1:0]   idx_q, idx_d;
    logic [J_WIDTH-1:0]   count_d;
    logic [J_WIDTH-1:0]   wr_lane;
    logic [J*DW-1:0]      vec_q;
    logic                 sent_q, sent_d;
    logic                 err_s_d, err_l_d;
    logic                 clear, fill_beat, beat, take;

    assign m_tdata = vec_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        count_d   = m_count;
        sent_d    = sent_q;
        err_s_d   = 1'b0;
        err_l_d   = 1'b0;
        clear     = 1'b0;
        fill_beat = 1'b0;
        wr_lane   = idx_q;
        s_tready  = 1'b1;
        m_tvalid  = 1'b0;

        case (state_q)
            FULL:    begin m_tvalid = 1'b1; s_tready = m_tready; end
            DROP:    m_tvalid = !sent_q;
            default: ;
        endcase

        beat = s_tvalid && s_tready;
        take = m_tvalid && m_tready;

        case (state_q)
            FILL: fill_beat = beat;
            FULL: begin
                if (take) begin
                    clear     = 1'b1;
                    idx_d     = '0;
                    count_d   = '0;
                    state_d   = FILL;
                    wr_lane   = '0;
                    fill_beat = beat;
                end
            end
            DROP: begin
                // sent_q remembers an early handshake so the vector is not re-presented
                if (take) begin
                    clear   = 1'b1;
                    sent_d  = 1'b1;
                    idx_d   = '0;
                    count_d = '0;
                end
                if (beat && s_tlast) begin
                    sent_d  = 1'b0;
                    state_d = (sent_q || take) ? FILL : FULL;
                end
            end
            default: state_d = FILL;
        endcase

        // Shared by FILL beats and the same-cycle first beat after a FULL handshake
        if (fill_beat) begin
            idx_d = wr_lane + J_WIDTH'(1);
            if (wr_lane == LAST_IDX) begin
                count_d = FULL_CNT;
                if (s_tlast) begin
                    state_d = FULL;
                end else begin
                    state_d = DROP;
                    sent_d  = 1'b0;
                    err_l_d = 1'b1;
                end
            end else if (s_tlast) begin
                state_d = FULL;
                count_d = wr_lane + J_WIDTH'(1);
                err_s_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            idx_q     <= '0;
            m_count   <= '0;
            sent_q    <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            vec_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            m_count   <= count_d;
            sent_q    <= sent_d;
            err_short <= err_s_d;
            err_long  <= err_l_d;
            if (clear) vec_q <= '0;
            for (int unsigned j = 0; j < J; j++) begin
                if (fill_beat && wr_lane == J_WIDTH'(j)) vec_q[j*DW +: DW] <= s_tdata;
            end
        end
    end

endmodule

// File: tb/tb_f_vector_pack.sv
// Self-checking bench for f_vector_pack: directed frame table, corner sequences, random traffic.
module tb_f_vector_pack;

    localparam int J  = 14;
    localparam int DW = 64;
    localparam int JW = $clog2(J) + 1;
    localparam int VW = J * DW;

    logic            clk;
    logic            rst_n;
    logic [DW-1:0]   s_tdata;
    logic            s_tvalid;
    logic            s_tlast;
    logic            s_tready;
    logic [VW-1:0]   m_tdata;
    logic            m_tvalid;
    logic            m_tready;
    logic [JW-1:0]   m_count;
    logic            err_short;
    logic            err_long;

    logic rand_ready, rnd_ready, man_ready;
    assign m_tready = rand_ready ? rnd_ready : man_ready;

    f_vector_pack #(.J(J), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_count(m_count),
        .err_short(err_short), .err_long(err_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1 rnd_ready = ($urandom_range(0, 3) != 0);
    end

    int total = 0;
    int bad   = 0;

    task automatic check_v(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Reference model: frames are tracked by beat position only.
    typedef struct {
        logic [VW-1:0] vec;
        int            cnt;
    } exp_t;

    exp_t          expq[$];
    logic [VW-1:0] cur_vec;
    int            pos = 0;
    int            exp_short = 0, exp_long = 0;
    int            seen_short = 0, seen_long = 0;
    int            n_vec = 0;
    int            last_count = 0;
    logic [VW-1:0] last_vec;
    logic          held = 1'b0;
    logic [VW-1:0] held_vec;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            pos     = 0;
            cur_vec = '0;
            held    = 1'b0;
            expq.delete();
        end else begin
            if (held && m_tvalid) check_v("hold_stable", m_tdata, held_vec);
            held     = m_tvalid && !m_tready;
            held_vec = m_tdata;
            if (err_short) begin
                seen_short++;
                check_i("short_with_valid", int'(m_tvalid), 1);
            end
            if (err_long) seen_long++;
            if (m_tvalid && m_tready) begin
                n_vec++;
                last_count = int'(m_count);
                last_vec   = m_tdata;
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL vector_unexpected: got count %0d want no vector", m_count);
                end else begin
                    e = expq.pop_front();
                    check_v("vec_data", m_tdata, e.vec);
                    check_i("vec_count", int'(m_count), e.cnt);
                end
            end
            if (s_tvalid && s_tready) begin
                if (pos < J) cur_vec[pos*DW +: DW] = s_tdata;
                if (pos == J - 1 && !s_tlast) exp_long++;
                if (s_tlast && pos < J - 1) exp_short++;
                if (pos == J - 1 || (s_tlast && pos < J)) begin
                    e.vec = cur_vec;
                    e.cnt = pos + 1;
                    expq.push_back(e);
                    cur_vec = '0;
                end
                pos = s_tlast ? 0 : pos + 1;
            end
        end
    end

    task automatic beat(input logic [DW-1:0] d, input bit last, output int waited);
        waited   = 0;
        s_tdata  = d;
        s_tvalid = 1'b1;
        s_tlast  = last;
        @(negedge clk);
        while (!s_tready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!s_tready) begin
            total++;
            bad++;
            $display("FAIL beat_timeout: s_tready still 0 after %0d cycles", waited);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic frame(input int n, input int base, input bit gaps);
        int w;
        for (int k = 0; k < n; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            beat($realtobits(real'(base + k + 1)), k == n - 1, w);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        int nbeats;
        int exp_count;
        int exp_short;
        int exp_long;
    } vec_rec_t;

    initial begin
        vec_rec_t      tbl[6];
        logic [VW-1:0] exp3;
        int            s0, l0, v0, w;

        rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
        man_ready = 1'b1; rand_ready = 1'b0; rnd_ready = 1'b1;

        wait_cycles(3);
        check_i("rst_tvalid", int'(m_tvalid), 0);
        check_v("rst_tdata", m_tdata, '0);
        check_i("rst_count", int'(m_count), 0);
        check_i("rst_errs", int'({err_short, err_long}), 0);
        check_i("rst_tready", int'(s_tready), 1);
        rst_n = 1'b1;
        wait_cycles(1);

        tbl[0] = '{14, 14, 0, 0};
        tbl[1] = '{3,  3,  1, 0};
        tbl[2] = '{16, 14, 0, 1};
        tbl[3] = '{1,  1,  1, 0};
        tbl[4] = '{13, 13, 1, 0};
        tbl[5] = '{15, 14, 0, 1};
        for (int i = 0; i < 6; i++) begin
            s0 = seen_short; l0 = seen_long; v0 = n_vec;
            frame(tbl[i].nbeats, 0, 1'b0);
            wait_cycles(3);
            check_i("tbl_vectors", n_vec - v0, 1);
            check_i("tbl_count", last_count, tbl[i].exp_count);
            check_i("tbl_short", seen_short - s0, tbl[i].exp_short);
            check_i("tbl_long", seen_long - l0, tbl[i].exp_long);
        end

        beat($realtobits(2.5), 1'b0, w);
        beat($realtobits(-1.0), 1'b0, w);
        beat($realtobits(7.0), 1'b1, w);
        wait_cycles(2);
        exp3 = '0;
        exp3[0*DW +: DW] = $realtobits(2.5);
        exp3[1*DW +: DW] = $realtobits(-1.0);
        exp3[2*DW +: DW] = $realtobits(7.0);
        check_v("three_beat_vec", last_vec, exp3);

        man_ready = 1'b0;
        frame(14, 100, 1'b0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_i("stall_tready", int'(s_tready), 0);
            check_i("stall_tvalid", int'(m_tvalid), 1);
        end
        @(posedge clk);
        #1;
        man_ready = 1'b1;
        beat($realtobits(500.0), 1'b0, w);
        check_i("stall_release_same_cycle", w, 0);
        frame(13, 500, 1'b0);
        wait_cycles(3);
        check_v("stall_lane0", {{(VW-DW){1'b0}}, last_vec[DW-1:0]}, {{(VW-DW){1'b0}}, $realtobits(500.0)});

        v0 = n_vec;
        for (int k = 0; k < 28; k++) begin
            beat($realtobits(real'(1000 + k)), (k % 14) == 13, w);
            check_i("b2b_no_stall", w, 0);
        end
        wait_cycles(2);
        check_i("b2b_vectors", n_vec - v0, 2);

        frame(5, 2000, 1'b0);
        s_tvalid = 1'b1; s_tdata = '1;
        wait_cycles(1);
        rst_n = 1'b0;
        s_tvalid = 1'b0;
        #1;
        check_i("midrst_tvalid", int'(m_tvalid), 0);
        check_v("midrst_tdata", m_tdata, '0);
        check_i("midrst_count", int'(m_count), 0);
        check_i("midrst_errs", int'({err_short, err_long}), 0);
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(1);
        v0 = n_vec;
        frame(14, 3000, 1'b0);
        wait_cycles(3);
        check_i("postrst_vectors", n_vec - v0, 1);
        check_i("postrst_count", last_count, 14);

        rand_ready = 1'b1;
        for (int f = 0; f < 200; f++) begin
            int n;
            n = $urandom_range(1, 17);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
                beat({$urandom, $urandom}, k == n - 1, w);
            end
        end
        rand_ready = 1'b0;
        man_ready  = 1'b1;
        for (int c = 0; c < 50 && expq.size() != 0; c++) wait_cycles(1);
        wait_cycles(2);
        check_i("drain_empty", expq.size(), 0);
        check_i("total_short", seen_short, exp_short);
        check_i("total_long", seen_long, exp_long);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
